// File: rtl/motor_ctrl_track.sv
// motor_ctrl_track: centroid/proximity tracker producing slew-limited signed dps commands
// for a differential-drive robot, with bounded search and give-up on object loss.
module motor_ctrl_track #(
    parameter int NB_DPS     = 16,
    parameter int NB_CENT    = 8,
    parameter int NB_LOST    = 6,
    parameter int NB_SRCH    = 5,
    parameter int VEL_P0     = 600,
    parameter int VEL_P1     = 550,
    parameter int VEL_P2     = 450,
    parameter int VEL_P3     = 350,
    parameter int VEL_P4     = 250,
    parameter int VEL_P5     = 150,
    parameter int VEL_P6     = -250,
    parameter int VEL_P7     = -450,
    parameter int STEER_BASE = 125,
    parameter int STEER_STEP = 50,
    parameter int SEARCH_VEL = 250,
    parameter int RAMP_STEP  = 50,
    parameter int RAMP_DIV   = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [NB_CENT-1:0]       centroid,
    input  logic                     new_centroid,
    input  logic [2:0]               proximity,
    output logic signed [NB_DPS-1:0] motor_dps_left_o,
    output logic signed [NB_DPS-1:0] motor_dps_rght_o,
    output logic [2:0]               state_o,
    output logic                     lost_o
);
    localparam int H  = NB_CENT / 2;
    localparam int CW = (NB_LOST > NB_SRCH) ? NB_LOST : NB_SRCH;
    localparam int W  = NB_DPS + 2;
    localparam int D  = NB_DPS + 1;
    localparam int DW = $clog2(RAMP_DIV + 1);
    localparam logic [CW-1:0] LOST_T = CW'((1 << NB_LOST) - 1);
    localparam logic [CW-1:0] SRCH_T = CW'((1 << NB_SRCH) - 1);
    localparam logic signed [W-1:0] MAXW = W'((2 ** (NB_DPS - 1)) - 1);
    localparam logic signed [W-1:0] MINW = -W'(2 ** (NB_DPS - 1));
    localparam logic signed [W-1:0] SV = W'(SEARCH_VEL);
    localparam logic signed [D-1:0] STP = D'(RAMP_STEP);
    localparam logic signed [NB_DPS-1:0] STPN = NB_DPS'(RAMP_STEP);
    localparam logic signed [W-1:0] VEL [8] = '{W'(VEL_P0), W'(VEL_P1), W'(VEL_P2), W'(VEL_P3),
                                                 W'(VEL_P4), W'(VEL_P5), W'(VEL_P6), W'(VEL_P7)};

    typedef enum logic [2:0] {IDLE, WAIT, TRACK, SEARCH, GIVEUP} state_t;

    state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic [NB_CENT-1:0] last_cent;
    logic last_seen_left;
    logic valid;
    logic [DW-1:0] div;
    logic tick;
    logic [H-1:0] rh, lh;
    logic use_right, centred, fwd, slow_left;
    int d_r, d_l;
    logic signed [W-1:0] v, corr, slow, tl, tr;
    logic signed [NB_DPS-1:0] tgt_l, tgt_r;

    function automatic logic signed [NB_DPS-1:0] sat(input logic signed [W-1:0] x);
        return (x > MAXW) ? MAXW[NB_DPS-1:0] : (x < MINW) ? MINW[NB_DPS-1:0] : x[NB_DPS-1:0];
    endfunction

    // Differences are taken one bit wider than the outputs so full-scale swings cannot wrap.
    function automatic logic signed [NB_DPS-1:0] ramp(input logic signed [NB_DPS-1:0] o,
                                                      input logic signed [NB_DPS-1:0] t);
        logic signed [D-1:0] df;
        df = D'(t) - D'(o);
        return (df > STP) ? o + STPN : (df < -STP) ? o - STPN : t;
    endfunction

    assign valid   = new_centroid && (centroid != '0);
    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
    assign tick    = (div == DW'(RAMP_DIV - 1));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (state == IDLE) begin
            state_nxt = WAIT;
            cnt_nxt   = '0;
        end else if (valid) begin
            state_nxt = TRACK;
            cnt_nxt   = '0;
        end else if (new_centroid) begin
            cnt_nxt = cnt_inc;
            if ((state == WAIT || state == TRACK) && cnt_inc >= LOST_T) begin
                state_nxt = SEARCH;
                cnt_nxt   = '0;
            end else if (state == SEARCH && cnt_inc >= SRCH_T) begin
                state_nxt = GIVEUP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            last_cent      <= '0;
            last_seen_left <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (enable && valid) begin
                last_cent      <= centroid;
                last_seen_left <= |centroid[NB_CENT-1:H];
            end
        end
    end

    assign rh        = last_cent[H-1:0];
    assign lh        = last_cent[NB_CENT-1:H];
    assign use_right = |rh;
    assign centred   = last_cent[H] & last_cent[H-1];

    // Distance from centre of the innermost occupied bin in each half.
    always_comb begin
        d_r = 0;
        d_l = 0;
        for (int i = 0; i < H; i++)
            if (rh[i]) d_r = H - 1 - i;
        for (int i = H - 1; i >= 0; i--)
            if (lh[i]) d_l = i;
    end

    assign v         = VEL[proximity];
    assign corr      = W'(STEER_BASE) + W'((use_right ? d_r : d_l) * STEER_STEP);
    assign fwd       = v > 0;
    assign slow      = fwd ? ((v - corr > 0) ? v - corr : '0) : ((v + corr < 0) ? v + corr : '0);
    assign slow_left = (use_right == fwd);

    always_comb begin
        tl = '0;
        tr = '0;
        if (state == TRACK) begin
            tl = (centred || !slow_left) ? v : slow;
            tr = (centred || slow_left) ? v : slow;
        end else if (state == SEARCH) begin
            tl = last_seen_left ? SV : -SV;
            tr = last_seen_left ? -SV : SV;
        end
        tgt_l = sat(tl);
        tgt_r = sat(tr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div              <= '0;
            motor_dps_left_o <= '0;
            motor_dps_rght_o <= '0;
        end else begin
            div <= tick ? '0 : div + 1'b1;
            if (!enable) begin
                motor_dps_left_o <= '0;
                motor_dps_rght_o <= '0;
            end else if (RAMP_STEP == 0) begin
                motor_dps_left_o <= tgt_l;
                motor_dps_rght_o <= tgt_r;
            end else if (tick) begin
                motor_dps_left_o <= ramp(motor_dps_left_o, tgt_l);
                motor_dps_rght_o <= ramp(motor_dps_rght_o, tgt_r);
            end
        end
    end

    assign state_o = state;
    assign lost_o  = (state == SEARCH) || (state == GIVEUP);
endmodule

// File: doc/motor_ctrl_track.md
# motor_ctrl_track

Parametrised successor to the SPI motor controller that converts a camera centroid and a proximity code into signed degrees-per-second commands for the left and right GoPiGo motors. It sits between the centroid/proximity extraction pipeline and the SPI motor-command serializer. It adds the following:
- configurable centroid width and speed table;
- a bounded search phase followed by a give-up stop;
- steering clamped so the slow wheel never reverses;
- slew-rate limiting on both outputs.

## Interface
Parameters:
- NB_DPS, 16: width of the signed motor dps outputs.
- NB_CENT, 8: centroid bins; even and at least 4. Bit NB_CENT-1 is the leftmost bin.
- NB_LOST, 6: consecutive empty frames before searching is 2^NB_LOST-1.
- NB_SRCH, 5: search duration is 2^NB_SRCH-1 frames before giving up.
- VEL_P0..VEL_P7, 600/550/450/350/250/150/-250/-450: signed speed for proximity codes 0..7.
- STEER_BASE, 125: correction for the centre-adjacent bin.
- STEER_STEP, 50: extra correction per bin of distance from the centre.
- SEARCH_VEL, 250: spin magnitude while searching.
- RAMP_STEP, 50: maximum output change per ramp tick; 0 bypasses the ramp.
- RAMP_DIV, 1024: clocks per ramp tick; must be at least 1.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: reset. Reset is asynchronous and active-low; there is one clock.
- enable, in, 1: when 0, forces IDLE and zero outputs.
- centroid, in, NB_CENT: bin occupancy; all-zero means no object.
- new_centroid, in, 1: one-cycle frame strobe.
- proximity, in, 3: 0 is very far, 7 is very close.
- motor_dps_left_o, out, NB_DPS: signed left command.
- motor_dps_rght_o, out, NB_DPS: signed right command.
- state_o, out, 3: IDLE=0, WAIT=1, TRACK=2, SEARCH=3, GIVEUP=4.
- lost_o, out, 1: high in SEARCH or GIVEUP.

## Operation
- **Half split:** H = NB_CENT/2. The left half is bits [NB_CENT-1:H]; the right half is bits [H-1:0].
- **Centred:** the object is centred when bits H and H-1 are both set.
- **Frame strobe with centroid ≠ 0:**
  - last_cent <= centroid and the frame counter clears.
  - last_seen_left <= 1 if the left half is non-zero; otherwise it is cleared to 0.
- **Frame strobe with centroid = 0:** the frame counter increments.
- **States:**
  - IDLE: entered on reset or when enable=0. When enable=1, go to WAIT with the counter cleared.
  - WAIT: target is 0/0. A valid frame goes to TRACK. A count of 2^NB_LOST-1 goes to SEARCH.
  - TRACK: steer toward last_cent. A count of 2^NB_LOST-1 goes to SEARCH and clears the counter.
  - SEARCH: spin. If last_seen_left=1, target is left=+SEARCH_VEL, right=-SEARCH_VEL; otherwise the mirror. A valid frame goes to TRACK. A count of 2^NB_SRCH-1 goes to GIVEUP.
  - GIVEUP: target is 0/0. A valid frame goes to TRACK.
- **Counter saturation:** the counter saturates and never wraps.
- **Steering in TRACK:** v = VEL_P[proximity].
  - Centred: both targets are v.
  - Otherwise, select the right half if it is non-zero, else the left half. Within the selected half, take the set bit nearest the centre. Its distance d is 0 at bit H-1 or bit H.
  - corr = STEER_BASE + d*STEER_STEP.
- **Slow-side value:**
  - Forward (v > 0): slow = max(v - corr, 0).
  - Reverse (v < 0): slow = min(v + corr, 0).
- **Which wheel is slow:**
  - Right half selected: left is slow going forward, right is slow in reverse.
  - Left half selected: the mirror of the above.
  - The other wheel gets v.
- **Arithmetic:** all steering arithmetic is signed, in NB_DPS+2 bits, then saturated to NB_DPS.

## Timing
- **Reset:** outputs are 0, state is IDLE, lost_o=0, last_cent=0, last_seen_left=0, and the counter and ramp divider are 0.
- **State update:** state, counter and last_cent update on the clk edge where new_centroid=1. The target is combinational from those registers and proximity.
- **Ramp tick:** a divider counts 0..RAMP_DIV-1 and ticks on the terminal count. RAMP_DIV=1 ticks every cycle.
- **Ramp step:** on a tick, each output moves toward its target by min(|target-out|, RAMP_STEP).
  - The difference is computed in NB_DPS+1 bits.
  - Outputs never overshoot.
  - A target change mid-ramp redirects from the current value.
- **Ramp bypass:** with RAMP_STEP=0, outputs equal the target one clock after the target changes.
- **Disable:** enable=0 zeroes both outputs on the next edge, bypassing the ramp, and enters IDLE.
- **Reset mid-operation:** rst_n low zeroes everything immediately.
- **Simultaneous events:** new_centroid while enable=0 is ignored. A valid frame coinciding with a counter terminal count takes the valid-frame path.

## Test plan
- **Straight tracking:**
  - Setup: RAMP_STEP=0, enable=1, proximity=0.
  - Stimulus: strobe centroid 8'b00011000.
  - Expect: state_o=2, both outputs 600 within 2 clocks.
- **Steering and clamping** with centroid 8'b00000001:
  - proximity=3: left 75, right 350.
  - proximity=5: left 0 (clamped), right 150.
  - proximity=7: left -450, right -175.
- **Loss, search and recovery:**
  - After tracking 8'b10000000, send 63 empty strobes: expect SEARCH, lost_o=1, left 250, right -250.
  - Then 31 more empty strobes: expect GIVEUP, 0/0.
  - Then strobe 8'b00010000 with proximity=0: expect TRACK, left 600, right 475.
- **Ramp:**
  - Setup: RAMP_STEP=50, RAMP_DIV=4, target 600 from 0.
  - Expect: +50 every 4 clocks, 600 reached after 12 ticks.
  - After 3 ticks, retarget to 100: expect 150 then 100, no overshoot.
- **Disable and reset:**
  - Drop enable mid-ramp: expect 0/0 and IDLE on the next edge.
  - Assert rst_n low between edges: expect outputs 0 asynchronously.
- **Width scaling:** with NB_CENT=16 and proximity=0, strobe bit 0 only. Expect corr 475, left 125, right 600.
